// File: rtl/contador_modulo_n.sv
// Parametrised up/down modulo counter with load, wrap/one-shot modes, TC pulse and DONE flag.
// Optional prescaler on the count enable is built when CONTADOR_PRESCALER_EN is defined.
module contador_modulo_n #(
  parameter int WIDTH     = 4,
  parameter int MODULO    = 11,
  parameter int PRESC_DIV = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             ONESHOT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] salida,
  output logic             TC,
  output logic             DONE
);

  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] lim_m1;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_next;
  logic             count_tc;
  logic             count_done;
  logic             step;

  // LIM is never zero: a zero LIMIT falls back to MODULO-1, which is at least 1.
  always_comb begin
    lim          = (LIMIT == '0) ? WIDTH'(MODULO - 1) : LIMIT;
    lim_m1       = lim - WIDTH'(1);
    load_clamped = (LOAD_VAL > lim) ? lim : LOAD_VAL;
  end

  always_comb begin
    count_next = salida;
    count_tc   = 1'b0;
    count_done = 1'b0;
    if (UP) begin
      if (ONESHOT) begin
        // A value already above a lowered limit is clamped onto LIM as the terminal.
        if (salida >= lim_m1) begin
          count_next = lim;
          count_tc   = 1'b1;
          count_done = 1'b1;
        end else begin
          count_next = salida + WIDTH'(1);
        end
      end else begin
        if (salida >= lim) begin
          count_next = '0;
          count_tc   = 1'b1;
        end else begin
          count_next = salida + WIDTH'(1);
        end
      end
    end else begin
      if (salida == '0) begin
        count_next = ONESHOT ? '0 : lim;
        count_tc   = 1'b1;
        count_done = ONESHOT;
      end else if (ONESHOT && (salida == WIDTH'(1))) begin
        count_next = '0;
        count_tc   = 1'b1;
        count_done = 1'b1;
      end else begin
        count_next = salida - WIDTH'(1);
      end
    end
  end

`ifdef CONTADOR_PRESCALER_EN
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0] presc;

  assign step = EN & ~DONE & (presc == PRESC_LAST);

  // Prescaler only advances on cycles the main counter would otherwise accept.
  always_ff @(posedge CLK) begin
    if (RST || LOAD) begin
      presc <= '0;
    end else if (EN && !DONE) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    end
  end
`else
  assign step = EN & ~DONE & (PRESC_DIV >= 1);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      salida <= '0;
      TC     <= 1'b0;
      DONE   <= 1'b0;
    end else if (LOAD) begin
      salida <= load_clamped;
      TC     <= 1'b0;
      DONE   <= 1'b0;
    end else if (step) begin
      salida <= count_next;
      TC     <= count_tc;
      DONE   <= DONE | count_done;
    end else begin
      TC     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_contador_modulo_n.sv
// Self-checking bench for contador_modulo_n (default build): directed vector table plus
// randomized traffic compared against an arithmetic reference model.
module tb_contador_modulo_n;

  localparam int W   = 4;
  localparam int MOD = 11;

  logic         CLK = 1'b0;
  logic         RST;
  logic         EN;
  logic         UP;
  logic         ONESHOT;
  logic         LOAD;
  logic [W-1:0] LOAD_VAL;
  logic [W-1:0] LIMIT;
  logic [W-1:0] salida;
  logic         TC;
  logic         DONE;

  int vectors     = 0;
  int miscompares = 0;

  int m_s  = 0;
  int m_tc = 0;
  int m_d  = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       os;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] lim;
    int         es;
    int         etc;
    int         ed;
  } vec_t;

  vec_t vecs[$];

  always #5 CLK = ~CLK;

  contador_modulo_n #(
    .WIDTH(W),
    .MODULO(MOD),
    .PRESC_DIV(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .UP(UP),
    .ONESHOT(ONESHOT),
    .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL),
    .LIMIT(LIMIT),
    .salida(salida),
    .TC(TC),
    .DONE(DONE)
  );

  function automatic void add(input logic rst, en, up, os, ld, input int lv, lim, es, etc, ed);
    vec_t v;
    v.rst = rst; v.en = en; v.up = up; v.os = os; v.ld = ld;
    v.lv  = 4'(lv); v.lim = 4'(lim);
    v.es  = es; v.etc = etc; v.ed = ed;
    vecs.push_back(v);
  endfunction

  // Reference model: counts over the ring 0..LIM with plain modular arithmetic.
  function automatic void modelStep(input logic rst, en, up, os, ld, input int lv, lim_in);
    int lim;
    int c;
    lim = (lim_in == 0) ? MOD - 1 : lim_in;
    if (rst) begin
      m_s = 0; m_tc = 0; m_d = 0;
    end else if (ld) begin
      m_s = (lv < lim) ? lv : lim; m_tc = 0; m_d = 0;
    end else if (en && m_d == 0) begin
      if (up && os) begin
        m_s  = (m_s + 1 < lim) ? m_s + 1 : lim;
        m_tc = (m_s == lim) ? 1 : 0;
        m_d  = m_tc;
      end else if (up) begin
        c    = (m_s > lim) ? lim : m_s;
        m_s  = (c + 1) % (lim + 1);
        m_tc = (m_s == 0) ? 1 : 0;
      end else if (os) begin
        m_s  = (m_s > 0) ? m_s - 1 : 0;
        m_tc = (m_s == 0) ? 1 : 0;
        m_d  = m_tc;
      end else if (m_s > lim) begin
        m_s  = m_s - 1; m_tc = 0;
      end else begin
        m_tc = (m_s == 0) ? 1 : 0;
        m_s  = (m_s + lim) % (lim + 1);
      end
    end else begin
      m_tc = 0;
    end
  endfunction

  task automatic applyStimulus(input logic rst, en, up, os, ld, input logic [3:0] lv, lim);
    @(negedge CLK);
    RST = rst; EN = en; UP = up; ONESHOT = os; LOAD = ld; LOAD_VAL = lv; LIMIT = lim;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input int es, etc, ed);
    vectors++;
    if (salida !== 4'(es) || TC !== 1'(etc) || DONE !== 1'(ed)) begin
      miscompares++;
      $display("[TB] FAIL %s: got salida=%0d TC=%0b DONE=%0b, expected salida=%0d TC=%0d DONE=%0d",
               name, salida, TC, DONE, es, etc, ed);
    end
  endtask

  initial begin
    int e;
    int tc;
    logic en;
    logic r_rst, r_en, r_up, r_os, r_ld;
    logic [3:0] r_lv, r_lim;

    RST = 1'b1; EN = 1'b0; UP = 1'b1; ONESHOT = 1'b0; LOAD = 1'b0;
    LOAD_VAL = '0; LIMIT = '0;

    for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) add(0, 1, 1, 0, 0, 0, 0, i % 11, (i == 11) ? 1 : 0, 0);

    e = 1;
    for (int blk = 0; blk < 8; blk++) begin
      en = 1'(blk % 2);
      for (int k = 0; k < 3; k++) begin
        tc = 0;
        if (en) begin
          e  = (e == 10) ? 0 : e + 1;
          tc = (e == 0) ? 1 : 0;
        end
        add(0, en, 1, 0, 0, 0, 0, e, tc, 0);
      end
    end

    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 10, 1, 0);
    for (int v = 9; v >= 7; v--) add(0, 1, 0, 0, 0, 0, 0, v, 0, 0);

    add(1, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      add(0, 1, 0, 0, 0, 0, 5, (i < 6) ? 5 - i : 5, (i == 0 || i == 6) ? 1 : 0, 0);

    add(0, 0, 1, 0, 1, 14, 0, 10, 0, 0);
    add(0, 1, 1, 0, 1, 3, 0, 3, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 4, 0, 0);
    add(0, 0, 1, 0, 1, 9, 5, 5, 0, 0);

    add(1, 0, 1, 1, 0, 0, 4, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 1, 1, 1, 0, 0, 4, (i < 4) ? i : 4, (i == 4) ? 1 : 0, (i >= 4) ? 1 : 0);
    add(0, 1, 1, 1, 1, 0, 4, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 4, 1, 0, 0);

    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, 1, 1, 0, 0, 0, 0, i, 0, 0);
    add(0, 1, 1, 0, 0, 0, 5, 0, 1, 0);
    for (int i = 1; i <= 6; i++) add(0, 1, 1, 0, 0, 0, 0, i, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 1; i <= 7; i++) add(0, 1, 1, 0, 0, 0, 0, i, 0, 0);
    add(0, 1, 1, 1, 0, 0, 5, 5, 1, 1);
    add(0, 1, 1, 0, 0, 0, 5, 5, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 5, 0, 1);

    add(0, 0, 0, 1, 1, 2, 0, 2, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0, 1);

    add(0, 0, 1, 0, 1, 5, 0, 5, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 6, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 5, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 6, 0, 0);

    $display("[TB] applying %0d directed vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].os, vecs[i].ld,
                    vecs[i].lv, vecs[i].lim);
      checkOutput($sformatf("vec%0d", i), vecs[i].es, vecs[i].etc, vecs[i].ed);
    end

    $display("[TB] randomized phase");
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    modelStep(1, 0, 1, 0, 0, 0, 0);
    checkOutput("rand_reset", m_s, m_tc, m_d);
    r_os  = 1'b0;
    r_lim = '0;
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(0, 59) == 0);
      r_ld  = ($urandom_range(0, 11) == 0);
      r_en  = ($urandom_range(0, 9) < 7);
      r_up  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) r_os = ~r_os;
      if ($urandom_range(0, 19) == 0) r_lim = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      r_lv  = 4'($urandom_range(0, 15));
      modelStep(r_rst, r_en, r_up, r_os, r_ld, int'(r_lv), int'(r_lim));
      applyStimulus(r_rst, r_en, r_up, r_os, r_ld, r_lv, r_lim);
      checkOutput($sformatf("rand%0d", i), m_s, m_tc, m_d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
